supply_valve_controller: RTL and testbench
==========================================

SUPPLY_VALVE_CONTROLLER -- requirements
Module: supply_valve_controller

Interface
REQ-001 Parameter LOW_LEVEL, default 3'd2: refill starts when level <= this value.
REQ-002 Parameter HIGH_LEVEL, default 3'd7: refill stops when level >= this value.
REQ-003 Parameter FILL_TIMEOUT, default 5'd16: ticks allowed without level rise before fault.
REQ-004 Parameter MIN_OFF, default 5'd4: ticks the valve stays closed after a completed fill.
REQ-005 Port clock  in  1  single system clock; all state on its rising edge.
REQ-006 Port reset  in  1  synchronous, active-high reset.
REQ-007 Port level  in  3  water level count from the level-tracking stage, 0 = empty, 7 = full.
REQ-008 Port enable  in  1  irrigation permitted; low forces the valve closed.
REQ-009 Port tick  in  1  one-cycle timing pulse from the clock divisor; all timers advance only on tick.
REQ-010 Port clear_alarm  in  1  operator acknowledge; leaves FAULT.
REQ-011 Port valve_open  out  1  supply valve drive, registered.
REQ-012 Port alarm  out  1  dry-supply fault indicator, registered.
REQ-013 Port state  out  2  current FSM state, for display.

Function
REQ-014 The FSM SHALL have states IDLE=2'b00, FILLING=2'b01, HOLD=2'b10, FAULT=2'b11.
REQ-015 valve_open SHALL be 1 only in FILLING; alarm SHALL be 1 only in FAULT; both SHALL be registered from next state, i.e. valid in the same cycle as state.
REQ-016 IDLE->FILLING SHALL occur when enable=1 and level<=LOW_LEVEL; the watchdog SHALL clear on entry.
REQ-017 In FILLING, priority SHALL be: level>=HIGH_LEVEL -> HOLD; else enable=0 -> IDLE; else watchdog==FILL_TIMEOUT -> FAULT; else stay.
REQ-018 The block SHALL register level every cycle as prev_level; in FILLING, level>prev_level SHALL clear the watchdog in that cycle, taking precedence over a coincident tick.
REQ-019 The watchdog SHALL be a 5-bit counter incrementing on tick in FILLING and saturating at FILL_TIMEOUT (no wrap).
REQ-020 HOLD entry SHALL clear the off-timer; the off-timer SHALL increment on tick, and HOLD->IDLE SHALL occur in the cycle the timer equals MIN_OFF, regardless of level or enable.
REQ-021 FAULT SHALL be left only via clear_alarm=1, going to IDLE; enable and level SHALL be ignored in FAULT.
REQ-022 A level drop in FILLING SHALL NOT clear the watchdog.
REQ-023 With MIN_OFF=0, HOLD SHALL last exactly one cycle.
REQ-024 tick held high continuously SHALL count once per cycle; no edge detection is required.

Reset
REQ-025 reset=1 at a clock edge SHALL force state=IDLE, valve_open=0, alarm=0, watchdog=0, off-timer=0, prev_level=0, overriding every other input, including mid-FILLING and in FAULT.
REQ-026 The first cycle after reset deasserts SHALL evaluate transitions normally, so IDLE->FILLING can occur immediately.

Structure
REQ-027 State encodings and default threshold constants SHALL be placed in a shared irrigation package used by this block and by the level-tracking stage.
REQ-028 The watchdog and the off-timer SHALL each be one instance of a sub-module tick_counter (clear, tick-enable, saturate-at-limit, 5-bit count).

Verification
REQ-029 reset, enable=1, level=1 -> FILLING and valve_open=1 one cycle after reset drops.
REQ-030 In FILLING, level stepped 1->7 over 6 ticks -> HOLD with valve_open=0 at level=7; returns to IDLE 4 ticks later; re-enters FILLING only when level<=2.
REQ-031 In FILLING, level constant at 1 with 16 ticks -> FAULT, alarm=1, valve_open=0; clear_alarm pulse -> IDLE, alarm=0.
REQ-032 In FILLING, level rises coincident with the tick that would reach 16 -> no FAULT, watchdog=0.
REQ-033 In FILLING, enable=0 and level=7 in the same cycle -> HOLD, not IDLE.
REQ-034 reset asserted in FAULT and in HOLD -> IDLE, alarm=0, and both timers 0 on the next cycle.

Source files
------------

// File: rtl/irrigation_pkg.sv
// Shared irrigation definitions: controller state encoding and default level/timing thresholds.
// Used by the supply valve controller and the level-tracking stage.
package irrigation_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StFilling = 2'b01,
        StHold    = 2'b10,
        StFault   = 2'b11
    } valve_state_e;

    localparam int unsigned LevelWidth = 3;
    localparam int unsigned CountWidth = 5;

    localparam logic [LevelWidth-1:0] LowLevelDefault    = 3'd2;
    localparam logic [LevelWidth-1:0] HighLevelDefault   = 3'd7;
    localparam logic [CountWidth-1:0] FillTimeoutDefault = 5'd16;
    localparam logic [CountWidth-1:0] MinOffDefault      = 5'd4;

endpackage

// File: rtl/tick_counter.sv
// Tick-enabled up-counter with synchronous clear and saturation at a limit.
// Clear takes precedence over a coincident tick.
module tick_counter #(
    parameter int unsigned Width = 5
) (
    input  logic             clk_i,
    input  logic             clear_i,
    input  logic             tick_i,
    input  logic [Width-1:0] limit_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (tick_i && (count_q < limit_i)) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/supply_valve_controller.sv
// Refill controller for the irrigation supply tank: opens the valve on low level, closes on high
// level, enforces a minimum off time after a fill and latches a dry-supply fault on no progress.
module supply_valve_controller
    import irrigation_pkg::*;
#(
    parameter logic [LevelWidth-1:0] LOW_LEVEL    = LowLevelDefault,
    parameter logic [LevelWidth-1:0] HIGH_LEVEL   = HighLevelDefault,
    parameter logic [CountWidth-1:0] FILL_TIMEOUT = FillTimeoutDefault,
    parameter logic [CountWidth-1:0] MIN_OFF      = MinOffDefault
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic [LevelWidth-1:0] level_i,
    input  logic                  enable_i,
    input  logic                  tick_i,
    input  logic                  clear_alarm_i,
    output logic                  valve_open_o,
    output logic                  alarm_o,
    output logic [1:0]            state_o
);

    valve_state_e          state_d, state_q;
    logic                  valve_open_q;
    logic                  alarm_q;
    logic [LevelWidth-1:0] prev_level_q;
    logic [CountWidth-1:0] wd_count;
    logic [CountWidth-1:0] off_count;
    logic                  level_rise;
    logic                  wd_clear;
    logic                  off_clear;

    assign level_rise = level_i > prev_level_q;

    // Watchdog only runs while filling; any rise in level restarts it, even on a tick cycle.
    assign wd_clear  = reset_i || (state_q != StFilling) || level_rise;
    assign off_clear = reset_i || (state_q != StHold);

    tick_counter #(
        .Width (CountWidth)
    ) u_watchdog (
        .clk_i   (clock_i),
        .clear_i (wd_clear),
        .tick_i  (tick_i && (state_q == StFilling)),
        .limit_i (FILL_TIMEOUT),
        .count_o (wd_count)
    );

    tick_counter #(
        .Width (CountWidth)
    ) u_off_timer (
        .clk_i   (clock_i),
        .clear_i (off_clear),
        .tick_i  (tick_i && (state_q == StHold)),
        .limit_i (MIN_OFF),
        .count_o (off_count)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (enable_i && (level_i <= LOW_LEVEL)) state_d = StFilling;
            end
            StFilling: begin
                if (level_i >= HIGH_LEVEL)          state_d = StHold;
                else if (!enable_i)                 state_d = StIdle;
                else if (wd_count == FILL_TIMEOUT)  state_d = StFault;
            end
            StHold: begin
                if (off_count == MIN_OFF) state_d = StIdle;
            end
            StFault: begin
                if (clear_alarm_i) state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            valve_open_q <= 1'b0;
            alarm_q      <= 1'b0;
            prev_level_q <= '0;
        end else begin
            state_q      <= state_d;
            valve_open_q <= (state_d == StFilling);
            alarm_q      <= (state_d == StFault);
            prev_level_q <= level_i;
        end
    end

    assign valve_open_o = valve_open_q;
    assign alarm_o      = alarm_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_supply_valve_controller.sv
// Bench for supply_valve_controller: cycle-level reference model plus directed scenarios.
module tb_supply_valve_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] level = 3'd1;
    logic       enable = 1'b1;
    logic       tick = 1'b0;
    logic       clr = 1'b0;
    logic       valve, alarm;
    logic [1:0] st;
    logic       valve0, alarm0;
    logic [1:0] st0;

    int total = 0;
    int bad = 0;
    bit cmp_on = 1'b0;

    always #5 clk = ~clk;

    supply_valve_controller dut (
        .clock_i       (clk),
        .reset_i       (reset),
        .level_i       (level),
        .enable_i      (enable),
        .tick_i        (tick),
        .clear_alarm_i (clr),
        .valve_open_o  (valve),
        .alarm_o       (alarm),
        .state_o       (st)
    );

    supply_valve_controller #(
        .MIN_OFF (5'd0)
    ) dut0 (
        .clock_i       (clk),
        .reset_i       (reset),
        .level_i       (level),
        .enable_i      (enable),
        .tick_i        (tick),
        .clear_alarm_i (clr),
        .valve_open_o  (valve0),
        .alarm_o       (alarm0),
        .state_o       (st0)
    );

    // Reference model: 0 idle, 1 filling, 2 hold, 3 fault; timers as plain integers.
    int m_st = 0, m_wd = 0, m_off = 0, m_prev = 0;

    always @(posedge clk) begin
        int nxt;
        if (reset) begin
            m_st = 0; m_wd = 0; m_off = 0; m_prev = 0;
        end else begin
            nxt = m_st;
            if (m_st == 0 && enable && level <= 2) nxt = 1;
            if (m_st == 1) begin
                if (level >= 7) nxt = 2;
                else if (!enable) nxt = 0;
                else if (m_wd == 16) nxt = 3;
            end
            if (m_st == 2 && m_off == 4) nxt = 0;
            if (m_st == 3 && clr) nxt = 0;
            if (m_st != 1 || int'(level) > m_prev) m_wd = 0;
            else if (tick) m_wd = (m_wd < 16) ? m_wd + 1 : 16;
            if (m_st != 2) m_off = 0;
            else if (tick) m_off = (m_off < 4) ? m_off + 1 : 4;
            m_prev = level;
            m_st = nxt;
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            total++;
            if (st != m_st[1:0] || valve != (m_st == 1) || alarm != (m_st == 3) ||
                int'(dut.wd_count) != m_wd || int'(dut.off_count) != m_off) begin
                bad++;
                $display("FAIL model t=%0t: got st=%0d v=%0d a=%0d wd=%0d off=%0d expected st=%0d v=%0d a=%0d wd=%0d off=%0d",
                         $time, st, valve, alarm, dut.wd_count, dut.off_count,
                         m_st, (m_st == 1), (m_st == 3), m_wd, m_off);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse(input logic [2:0] lvl);
        @(negedge clk);
        level = lvl;
        tick  = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        bit reached;
        @(posedge clk);
        cmp_on = 1'b1;
        @(negedge clk); #1;
        chk("reset_state", st, 0);
        chk("reset_valve", valve, 0);
        chk("reset_alarm", alarm, 0);
        reset = 1'b0;
        @(negedge clk); #1;
        chk("first_fill_state", st, 1);
        chk("first_fill_valve", valve, 1);

        // Climb 1->7 over six ticks, then minimum off time
        for (int l = 2; l <= 7; l++) pulse(3'(l));
        chk("hold_state", st, 2);
        chk("hold_valve", valve, 0);
        chk("min0_hold_state", st0, 2);
        @(negedge clk); #1;
        chk("min0_hold_one_cycle", st0, 0);
        for (int i = 0; i < 4; i++) pulse(3'd7);
        chk("hold_after_4_ticks", st, 2);
        @(negedge clk); #1;
        chk("idle_after_hold", st, 0);
        @(negedge clk); level = 3'd3;
        @(negedge clk); #1;
        chk("no_refill_at_3", st, 0);
        level = 3'd2;
        @(negedge clk); #1;
        chk("refill_at_2", st, 1);

        // Dry supply: constant level through 16 ticks
        @(negedge clk); reset = 1'b1; level = 3'd1;
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 15; i++) pulse(3'd1);
        chk("wd_15", dut.wd_count, 15);
        pulse(3'd1);
        chk("wd_16_still_filling", st, 1);
        @(negedge clk); #1;
        chk("fault_state", st, 3);
        chk("fault_alarm", alarm, 1);
        chk("fault_valve", valve, 0);
        enable = 1'b0; level = 3'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("fault_sticky", st, 3);
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0; #1;
        chk("cleared_state", st, 0);
        chk("cleared_alarm", alarm, 0);

        // Rise coincident with the tick that would reach the timeout
        @(negedge clk); enable = 1'b1; level = 3'd1;
        for (int i = 0; i < 15; i++) pulse(3'd1);
        pulse(3'd2);
        chk("rise_wd_zero", dut.wd_count, 0);
        chk("rise_no_fault", st, 1);

        // High level wins over enable low; tick held high counts every cycle
        @(negedge clk); enable = 1'b0; level = 3'd7;
        @(negedge clk); #1;
        chk("high_beats_disable", st, 2);
        tick = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("held_tick_off4", dut.off_count, 4);
        @(negedge clk); #1;
        chk("held_tick_idle", st, 0);
        tick = 1'b0;

        // Reset in HOLD
        @(negedge clk); enable = 1'b1; level = 3'd1;
        @(negedge clk); level = 3'd7;
        @(negedge clk); #1;
        chk("hold_again", st, 2);
        pulse(3'd7);
        pulse(3'd7);
        chk("hold_off2", dut.off_count, 2);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); #1;
        chk("rst_hold_state", st, 0);
        chk("rst_hold_off", dut.off_count, 0);
        reset = 1'b0; enable = 1'b0;

        // Reset in FAULT
        @(negedge clk); enable = 1'b1; level = 3'd1; tick = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            @(negedge clk); #1;
            if (st == 2'd3) reached = 1'b1;
        end
        chk("fault_via_held_tick", reached, 1);
        @(negedge clk); reset = 1'b1; tick = 1'b0;
        @(negedge clk); #1;
        chk("rst_fault_state", st, 0);
        chk("rst_fault_alarm", alarm, 0);
        chk("rst_fault_wd", dut.wd_count, 0);
        chk("rst_fault_off", dut.off_count, 0);
        reset = 1'b0; enable = 1'b0;
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
